// File: rtl/pa_spsram_pipe_ctrl.sv
// Single-port SRAM controller: behavioural array, valid/ready request and response channels, grouped write mask.
// Latency: a read presented in cycle c is returned with rsp_vld in cycle c+RD_LAT at the earliest. Writes complete at the accepting edge.
// Backpressure: a low rsp_rdy stalls the read pipeline. Reads are held off once RD_LAT reads are outstanding. Writes are never blocked.
//
// Ports:
//   forever_cpuclk   clock; every state update happens on its rising edge
//   cpurst_b         synchronous active-low reset
//   req_vld/req_rdy  request handshake
//   req_wr           1 = write, 0 = read
//   req_addr         entry index
//   req_wdata        write data
//   req_wmask        active-high write enable, one bit per group of DATA_WIDTH/WE_WIDTH bits
//   rsp_vld/rsp_rdy  read response handshake
//   rsp_rdata        read data; held stable while rsp_vld & ~rsp_rdy
//   init_done        array usable; requests are accepted only while it is high
//
// Optional feature: define PA_SPSRAM_INIT_EN to zero-fill the whole array after every reset.
// The array cannot be used until the fill has finished.
// RD_LAT must be 1 or 2, and DATA_WIDTH must be a multiple of WE_WIDTH.

module pa_spsram_pipe_ctrl #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 37,
  parameter int WE_WIDTH   = 37,
  parameter int RD_LAT     = 1
) (
  input  logic                  forever_cpuclk,
  input  logic                  cpurst_b,
  input  logic                  req_vld,
  output logic                  req_rdy,
  input  logic                  req_wr,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [WE_WIDTH-1:0]   req_wmask,
  output logic                  rsp_vld,
  input  logic                  rsp_rdy,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  init_done
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int GRP   = DATA_WIDTH / WE_WIDTH;
  // Width of the outstanding-read count: it must hold values 0..RD_LAT.
  localparam int OW    = $clog2(RD_LAT + 1);
  localparam logic [OW-1:0] RD_LAT_W = OW'(RD_LAT);

  // --------------------------------------------------------------------
  // Storage and internal state
  // --------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Read pipeline. Stage 0 is loaded at the access edge. Stage RD_LAT-1 drives rsp_*.
  logic [RD_LAT-1:0]     s_vld;
  logic [DATA_WIDTH-1:0] s_dat [RD_LAT];
  logic [RD_LAT-1:0]     stg_adv;
  logic [OW-1:0]         outstanding;

  logic [DATA_WIDTH-1:0] wbits;
  logic                  wr_acc;
  logic                  rd_acc;

  // Write port shared with the zero-fill sequencer.
  logic                  clr_we;
  logic [ADDR_WIDTH-1:0] clr_addr;

  // --------------------------------------------------------------------
  // Handshake
  // --------------------------------------------------------------------
  assign rsp_vld   = s_vld[RD_LAT-1];
  assign rsp_rdata = s_dat[RD_LAT-1];

  // Each valid stage holds exactly one accepted read that has not been consumed.
  always_comb begin
    outstanding = '0;
    for (int k = 0; k < RD_LAT; k++) begin
      outstanding = outstanding + OW'(s_vld[k]);
    end
  end

  // A read may enter when a slot is free now, or when the response drains this same edge.
  assign req_rdy = init_done & (req_wr | (outstanding < RD_LAT_W) | (rsp_vld & rsp_rdy));
  assign wr_acc  = req_vld & req_rdy & req_wr;
  assign rd_acc  = req_vld & req_rdy & ~req_wr;

  // Expand the per-group enables into per-bit enables.
  always_comb begin
    wbits = '0;
    for (int g = 0; g < WE_WIDTH; g++) begin
      wbits[g*GRP +: GRP] = {GRP{req_wmask[g]}};
    end
  end

  // --------------------------------------------------------------------
  // Read pipeline
  // --------------------------------------------------------------------
  // Stage k may take new contents when it, or any stage after it, is empty.
  // It may also take new contents when the output stage drains this cycle.
  // Those cases are exactly the ones in which every occupant downstream of k can move.
  always_comb begin
    stg_adv = '0;
    for (int k = 0; k < RD_LAT; k++) begin
      stg_adv[k] = rsp_rdy;
      for (int j = k; j < RD_LAT; j++) begin
        if (!s_vld[j]) begin
          stg_adv[k] = 1'b1;
        end
      end
    end
  end

  // Array data is sampled at the access edge.
  // A later write to the same entry therefore cannot alter a read that is already in flight.
  always_ff @(posedge forever_cpuclk) begin
    if (!cpurst_b) begin
      s_vld <= '0;
      for (int k = 0; k < RD_LAT; k++) begin
        s_dat[k] <= '0;
      end
    end else begin
      if (stg_adv[0]) begin
        s_vld[0] <= rd_acc;
        if (rd_acc) begin
          s_dat[0] <= mem[req_addr];
        end
      end
      for (int k = 1; k < RD_LAT; k++) begin
        if (stg_adv[k]) begin
          s_vld[k] <= s_vld[k-1];
          if (s_vld[k-1]) begin
            s_dat[k] <= s_dat[k-1];
          end
        end
      end
    end
  end

  // --------------------------------------------------------------------
  // Array write port
  // --------------------------------------------------------------------
  // The contents are deliberately not reset.
  // The zero-fill sequencer and user requests never collide, because req_rdy stays low while the fill runs.
  always_ff @(posedge forever_cpuclk) begin
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end else if (wr_acc) begin
      mem[req_addr] <= (mem[req_addr] & ~wbits) | (req_wdata & wbits);
    end
  end

  // --------------------------------------------------------------------
  // Initialisation
  // --------------------------------------------------------------------
`ifdef PA_SPSRAM_INIT_EN
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_READY = 2'd2
  } init_st_t;

  init_st_t              st_q;
  init_st_t              st_d;
  logic [ADDR_WIDTH-1:0] clr_cnt_q;
  logic [ADDR_WIDTH-1:0] clr_cnt_d;

  always_ff @(posedge forever_cpuclk) begin
    if (!cpurst_b) begin
      st_q      <= ST_IDLE;
      clr_cnt_q <= '0;
    end else begin
      st_q      <= st_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // IDLE lasts one cycle, and CLEAR lasts DEPTH cycles.
  // init_done therefore rises DEPTH+1 cycles after reset is released.
  always_comb begin
    st_d      = st_q;
    clr_cnt_d = clr_cnt_q;
    clr_we    = 1'b0;
    init_done = 1'b0;
    case (st_q)
      ST_IDLE: begin
        clr_cnt_d = '0;
        st_d      = ST_CLEAR;
      end
      ST_CLEAR: begin
        clr_we    = 1'b1;
        clr_cnt_d = clr_cnt_q + ADDR_WIDTH'(1);
        if (&clr_cnt_q) begin
          st_d = ST_READY;
        end
      end
      ST_READY: begin
        init_done = 1'b1;
      end
      default: begin
        st_d = ST_IDLE;
      end
    endcase
  end

  assign clr_addr = clr_cnt_q;
`else
  // Without zero-fill, the array becomes usable on the first edge after reset.
  logic ready_q;

  always_ff @(posedge forever_cpuclk) begin
    if (!cpurst_b) begin
      ready_q <= 1'b0;
    end else begin
      ready_q <= 1'b1;
    end
  end

  assign init_done = ready_q;
  assign clr_we    = 1'b0;
  assign clr_addr  = '0;
`endif

endmodule
